mio_responder: RTL and testbench

Memory/IO bus responder on the CPU's MIO interface. It accepts CPU requests (`CPU_MIO`, `mem_w`, `Addr_out`, `Data_out`), decodes the address into a wait-stated data RAM, a GPIO register and a free-running counter, and returns `Data_in` with a one-cycle `MIO_ready` pulse. It sits between the CPU core and on-board storage and peripherals, and owns all bus timing.

---
 rtl/mio_responder.sv | 184 ++++++++++++++++++
 tb/tb_mio_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mio_responder
//  Purpose  : Memory/IO bus responder for the CPU MIO interface. Decodes a
//             latched byte address into a wait-stated data RAM, a GPIO
//             register and a free-running 32-bit counter, and returns read
//             data with a one-cycle MIO_ready pulse (bus_err on unmapped).
//  Ports    : clk, reset (async, active-low)
//             CPU_MIO, mem_w, Addr_out[31:0], Data_out[31:0]  - CPU request
//             Data_in[31:0], MIO_ready, bus_err               - CPU response
//             gpio_in[31:0]  - switch inputs
//             gpio_out[31:0] - LED register
//  Revision : 1.0 - initial release
// ============================================================================
module mio_responder #(
    parameter int RAM_WORDS   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        bus_err,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
);

    localparam int         c_IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);
    localparam logic       c_HAS_WAIT  = (WAIT_STATES > 0);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;

    logic [31:2] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_wait_cnt;
    logic        r_ready;
    logic        r_err;
    logic [31:0] r_data_in;
    logic [31:0] r_gpio;
    logic [31:0] r_cnt;

    logic [31:0] r_mem [0:RAM_WORDS-1];

    logic [31:2] w_addr;
    logic [31:0] w_wdata;
    logic        w_we;
    logic        w_is_ram;
    logic        w_is_gpio;
    logic        w_is_cnt;
    logic        w_unmapped;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0] w_ram_rd;
    logic        w_accept;
    logic        w_commit;
    logic        w_ram_wr;

    // Byte-lane bits carry no meaning on this bus.
    wire w_unused_ok = &{1'b0, Addr_out[1:0]};

    // In IDLE the request is being latched on this very edge, so a
    // zero-wait access must decode and commit from the live bus signals.
    assign w_addr  = (r_state == c_IDLE) ? Addr_out[31:2] : r_addr;
    assign w_wdata = (r_state == c_IDLE) ? Data_out       : r_wdata;
    assign w_we    = (r_state == c_IDLE) ? mem_w          : r_we;

    assign w_is_ram   = (w_addr[31:28] == 4'h0) &&
                        ({1'b0, w_addr[27:2]} < 27'(RAM_WORDS));
    assign w_is_gpio  = (w_addr[31:28] == 4'hE);
    assign w_is_cnt   = (w_addr[31:28] == 4'hF);
    assign w_unmapped = !(w_is_ram || w_is_gpio || w_is_cnt);
    assign w_idx      = w_addr[c_IDX_W+1:2];
    assign w_ram_rd   = r_mem[w_idx];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (CPU_MIO) begin
                    w_next = (w_is_ram && c_HAS_WAIT) ? c_WAIT : c_DONE;
                end
            end
            c_WAIT: begin
                if (r_wait_cnt == 4'd1) begin
                    w_next = c_DONE;
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: output / strobe logic ----------------
    always_comb begin
        w_accept = (r_state == c_IDLE) && CPU_MIO;
        // Access effects land on the edge that enters DONE.
        w_commit = (r_state != c_DONE) && (w_next == c_DONE);
        // RAM has no reset, so gate it explicitly to drop in-flight writes.
        w_ram_wr = reset && w_commit && w_is_ram && w_we;
    end

    // ---------------- datapath / peripherals ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_wait_cnt <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_data_in  <= '0;
            r_gpio     <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= Addr_out[31:2];
                r_wdata    <= Data_out;
                r_we       <= mem_w;
                r_wait_cnt <= c_WAIT_INIT;
            end else if (r_state == c_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            r_ready <= w_commit;
            r_err   <= w_commit && w_unmapped;

            // A counter write overrides that cycle's increment.
            if (w_commit && w_is_cnt && w_we) begin
                r_cnt <= w_wdata;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_commit && w_is_gpio && w_we) begin
                r_gpio <= w_wdata;
            end

            if (w_commit && !w_we) begin
                if (w_is_ram) begin
                    r_data_in <= w_ram_rd;
                end else if (w_is_gpio) begin
                    r_data_in <= gpio_in;
                end else if (w_is_cnt) begin
                    r_data_in <= r_cnt;
                end else begin
                    r_data_in <= 32'hDEAD_BEEF;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign Data_in   = r_data_in;
    assign MIO_ready = r_ready;
    assign bus_err   = r_err;
    assign gpio_out  = r_gpio;

endmodule
`default_nettype wire

// File: tb/tb_mio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mio_responder
//  Purpose  : Self-checking bench for mio_responder. Expected responses are
//             queued when a request is driven and compared when MIO_ready
//             pulses; latency and side effects are checked by the driver.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mio_responder;

    localparam int RAM_WORDS   = 1024;
    localparam int WAIT_STATES = 2;
    localparam int RAM_LAT     = WAIT_STATES + 1;
    localparam int TIMEOUT     = 40;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        CPU_MIO  = 1'b0;
    logic        mem_w    = 1'b0;
    logic [31:0] Addr_out = '0;
    logic [31:0] Data_out = '0;
    logic [31:0] gpio_in  = '0;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        bus_err;
    logic [31:0] gpio_out;

    mio_responder #(
        .RAM_WORDS   (RAM_WORDS),
        .WAIT_STATES (WAIT_STATES)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (CPU_MIO),
        .mem_w     (mem_w),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .Data_in   (Data_in),
        .MIO_ready (MIO_ready),
        .bus_err   (bus_err),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_rd  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Response monitor: pops one expectation per MIO_ready pulse.
    always @(negedge clk) begin
        if (reset && MIO_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_ready", {31'b0, MIO_ready}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("data_in", Data_in, mon_e.data);
                check("bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
            end
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!MIO_ready && n < TIMEOUT);
        if (!MIO_ready) check("ready_timeout", {31'b0, MIO_ready}, 32'd1);
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_err,
                          input int exp_lat, input string tag);
        int  n;
        sb_t e;
        @(posedge clk);
        #1;
        CPU_MIO  = 1'b1;
        mem_w    = we;
        Addr_out = addr;
        Data_out = wd;
        if (!we) last_rd = exp_d;
        e.data = last_rd;
        e.err  = exp_err;
        sb_q.push_back(e);
        wait_ready(n);
        CPU_MIO = 1'b0;
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n1;
        int  n2;
        sb_t e;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",    {31'b0, MIO_ready}, 32'd0);
        check("rst_err",      {31'b0, bus_err},   32'd0);
        check("rst_data_in",  Data_in,            32'd0);
        check("rst_gpio_out", gpio_out,           32'd0);
        reset = 1'b1;

        // ---- seed RAM and GPIO, then reset mid-WAIT of a RAM write ----
        access(1'b1, 32'h0000_0010, 32'h1111_2222, 32'h0, 1'b0, RAM_LAT, "wr10");
        access(1'b1, 32'hE000_0000, 32'h0000_00A5, 32'h0, 1'b0, 1, "gpio_wr");
        check("gpio_out_a5", gpio_out, 32'h0000_00A5);
        access(1'b0, 32'h0000_0010, 32'h0, 32'h1111_2222, 1'b0, RAM_LAT, "rd10");

        @(posedge clk);
        #1;
        CPU_MIO  = 1'b1;
        mem_w    = 1'b1;
        Addr_out = 32'h0000_0010;
        Data_out = 32'h9999_0000;
        @(posedge clk);
        #1;
        CPU_MIO = 1'b0;
        reset   = 1'b0;
        #1;
        check("mid_rst_ready",    {31'b0, MIO_ready}, 32'd0);
        check("mid_rst_err",      {31'b0, bus_err},   32'd0);
        check("mid_rst_data_in",  Data_in,            32'd0);
        check("mid_rst_gpio_out", gpio_out,           32'd0);
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Counter restarted at 0; one edge elapses before the accept edge.
        access(1'b0, 32'hF000_0000, 32'h0, 32'h0000_0001, 1'b0, 1, "cnt_after_rst");
        access(1'b0, 32'h0000_0010, 32'h0, 32'h1111_2222, 1'b0, RAM_LAT, "rd10_kept");

        // ---- RAM write/read and address aliasing ----
        access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1'b0, RAM_LAT, "wr40");
        access(1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1'b0, RAM_LAT, "rd40");
        access(1'b1, 32'h0000_0043, 32'h0BAD_CAFE, 32'h0, 1'b0, RAM_LAT, "wr43");
        access(1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_CAFE, 1'b0, RAM_LAT, "rd40_alias");

        // ---- GPIO ----
        access(1'b1, 32'hE000_0000, 32'h0000_00A5, 32'h0, 1'b0, 1, "gpio_wr2");
        check("gpio_out_a5_2", gpio_out, 32'h0000_00A5);
        gpio_in = 32'h1234_5678;
        access(1'b0, 32'hE000_0000, 32'h0, 32'h1234_5678, 1'b0, 1, "gpio_rd");

        // ---- counter load, wrap and increment ----
        access(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 32'h0, 1'b0, 1, "cnt_wr_fe");
        access(1'b0, 32'hF000_0000, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, "cnt_rd_ff");
        access(1'b0, 32'hF000_0000, 32'h0, 32'h0000_0001, 1'b0, 1, "cnt_rd_wrap1");
        access(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, "cnt_wr_ff");
        access(1'b0, 32'hF000_0000, 32'h0, 32'h0000_0000, 1'b0, 1, "cnt_rd_zero");
        access(1'b0, 32'hF000_0000, 32'h0, 32'h0000_0002, 1'b0, 1, "cnt_rd_two");

        // ---- unmapped / out-of-range ----
        access(1'b1, 32'h0000_0000, 32'hA0A0_0000, 32'h0, 1'b0, RAM_LAT, "wr0");
        access(1'b1, 32'h0000_0004, 32'hB0B0_0004, 32'h0, 1'b0, RAM_LAT, "wr4");
        access(1'b0, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, "unmap_rd");
        access(1'b0, 32'(RAM_WORDS * 4), 32'h0, 32'hDEAD_BEEF, 1'b1, 1, "oor_rd");
        access(1'b1, 32'(RAM_WORDS * 4), 32'h5555_5555, 32'h0, 1'b1, 1, "oor_wr");
        access(1'b1, 32'h8000_0000, 32'h6666_6666, 32'h0, 1'b1, 1, "unmap_wr");
        check("gpio_out_untouched", gpio_out, 32'h0000_00A5);

        // ---- back-to-back RAM reads with CPU_MIO held high ----
        @(posedge clk);
        #1;
        CPU_MIO  = 1'b1;
        mem_w    = 1'b0;
        Addr_out = 32'h0000_0000;
        last_rd  = 32'hA0A0_0000;
        e.data   = last_rd;
        e.err    = 1'b0;
        sb_q.push_back(e);
        wait_ready(n1);
        check("b2b_lat0", 32'(n1), 32'(RAM_LAT));
        @(posedge clk);
        #1;
        Addr_out = 32'h0000_0004;
        last_rd  = 32'hB0B0_0004;
        e.data   = last_rd;
        sb_q.push_back(e);
        wait_ready(n2);
        CPU_MIO = 1'b0;
        check("b2b_spacing", 32'(n2 + 1), 32'(WAIT_STATES + 2));

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
